// File: rtl/video_sequencer.sv
// Character-slot sequencer: a free-running slot counter that times VRAM fetch,
// character ROM read, pixel pipeline advance, CRTC clock and ISA bus admission.
module video_sequencer #(
  parameter int SEQ_W      = 5,
  parameter int PERIOD     = 18,
  parameter int ROM_SLOT   = 1,
  parameter int READ_START = 1,
  parameter int READ_END   = 4,
  parameter int CHAR_SLOT  = 3,
  parameter int ATT_SLOT   = 4,
  parameter int ISA_START  = 6,
  parameter int ISA_END    = 16,
  parameter int ISA_LEN    = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             mode_slow,
  input  logic             isa_req,
  output logic [SEQ_W-1:0] clk_seq,
  output logic             phase,
  output logic             vram_read,
  output logic             vram_read_a0,
  output logic             vram_read_char,
  output logic             vram_read_att,
  output logic             charrom_read,
  output logic             disp_pipeline,
  output logic             crtc_clk,
  output logic             isa_op_enable,
  output logic             isa_grant,
  output logic             isa_busy
);

  // Slot constants held one bit wider than the counter so that ISA_END == PERIOD
  // and the fit sum never wrap.
  localparam logic [SEQ_W:0]   LAST_X  = (SEQ_W+1)'(PERIOD - 1);
  localparam logic [SEQ_W:0]   ROM_X   = (SEQ_W+1)'(ROM_SLOT);
  localparam logic [SEQ_W:0]   RS_X    = (SEQ_W+1)'(READ_START);
  localparam logic [SEQ_W:0]   RE_X    = (SEQ_W+1)'(READ_END);
  localparam logic [SEQ_W:0]   CHR_X   = (SEQ_W+1)'(CHAR_SLOT);
  localparam logic [SEQ_W:0]   ATT_X   = (SEQ_W+1)'(ATT_SLOT);
  localparam logic [SEQ_W:0]   IS_X    = (SEQ_W+1)'(ISA_START);
  localparam logic [SEQ_W:0]   IE_X    = (SEQ_W+1)'(ISA_END);
  localparam logic [SEQ_W:0]   LEN_X   = (SEQ_W+1)'(ISA_LEN);
  localparam logic [SEQ_W-1:0] LEN_M1  = SEQ_W'(ISA_LEN - 1);

  logic [SEQ_W-1:0] seq_nxt;
  logic [SEQ_W-1:0] busy_cnt;
  logic [SEQ_W-1:0] busy_nxt;
  logic [SEQ_W:0]   seq_x;
  logic             mode_q;
  logic             mode_nxt;
  logic             phase_nxt;
  logic             crtc_nxt;
  logic             wrap;
  logic             fetch_en;
  logic             low_seg;
  logic             fit;

  function automatic logic in_range(input logic [SEQ_W:0] v,
                                    input logic [SEQ_W:0] lo,
                                    input logic [SEQ_W:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  // An operation may start only if its last cycle still lies inside the window.
  function automatic logic op_fits(input logic [SEQ_W:0] v);
    return (v + LEN_X) <= IE_X;
  endfunction

  assign seq_x = {1'b0, clk_seq};
  assign wrap  = (seq_x == LAST_X);

  always_comb begin
    seq_nxt   = clk_seq + 1'b1;
    mode_nxt  = mode_q;
    phase_nxt = phase;
    crtc_nxt  = 1'b0;
    busy_nxt  = busy_cnt;
    if (wrap) begin
      seq_nxt   = '0;
      mode_nxt  = mode_slow;
      phase_nxt = mode_slow & ~phase;
      crtc_nxt  = ~(mode_slow & ~phase);
    end
    if (isa_grant) begin
      busy_nxt = LEN_M1;
    end else if (busy_cnt != '0) begin
      busy_nxt = busy_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_seq  <= '0;
      phase    <= 1'b0;
      mode_q   <= 1'b0;
      crtc_clk <= 1'b0;
      busy_cnt <= '0;
    end else begin
      clk_seq  <= seq_nxt;
      phase    <= phase_nxt;
      mode_q   <= mode_nxt;
      crtc_clk <= crtc_nxt;
      busy_cnt <= busy_nxt;
    end
  end

  // Phase 1 of half-rate mode fetches nothing, so its low segment joins the ISA window.
  assign fetch_en = ~mode_q | ~phase;
  assign low_seg  = mode_q & phase & (seq_x < IS_X);

  assign vram_read      = fetch_en & in_range(seq_x, RS_X, RE_X);
  assign charrom_read   = fetch_en & (seq_x == ROM_X);
  assign vram_read_char = fetch_en & (seq_x == CHR_X);
  assign vram_read_a0   = fetch_en & (seq_x == CHR_X);
  assign vram_read_att  = fetch_en & (seq_x == ATT_X);
  assign disp_pipeline  = fetch_en & (seq_x == ATT_X);

  assign isa_op_enable = ((seq_x >= IS_X) && (seq_x < IE_X)) || low_seg;
  assign fit           = low_seg | op_fits(seq_x);
  assign isa_busy      = (busy_cnt != '0);
  assign isa_grant     = isa_req & ~isa_busy & isa_op_enable & fit;

endmodule
